weight_stream_loader: RTL and testbench

//  Upstream write controller for the 8-channel weight buffer. Accepts a byte stream of conv weights,

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/weight_kernel_stage.sv | 29 ++
 rtl/weight_stream_loader.sv | 161 ++++++++++++++++
 tb/tb_weight_stream_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN loader types and constants.
// Kernel byte counts, conv type codes, loader FSM states.
package cnn_pkg;

    localparam int KERNEL_3X3_BYTES = 9;
    localparam int KERNEL_1X1_BYTES = 1;
    localparam int CH_NUM           = 8;

    localparam logic CONV_3X3 = 1'b0;
    localparam logic CONV_1X1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        EMIT,
        WRITE,
        DONE
    } ld_state_e;

    function automatic logic [3:0] kernel_bytes(input logic conv);
        return (conv == CONV_1X1) ? 4'(KERNEL_1X1_BYTES)
                                  : 4'(KERNEL_3X3_BYTES);
    endfunction

endpackage

// File: rtl/weight_kernel_stage.sv
// Staging store for one kernel (up to 9 bytes).
// Ports: i_clk/i_rst_n, write port (i_we, i_widx, i_wbyte), read mux (i_ridx -> o_rbyte).
module weight_kernel_stage
    import cnn_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  logic [3:0] i_widx,
    input  logic [7:0] i_wbyte,
    input  logic [3:0] i_ridx,
    output logic [7:0] o_rbyte
);

    logic [7:0] r_mem [KERNEL_3X3_BYTES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < KERNEL_3X3_BYTES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_widx < 4'(KERNEL_3X3_BYTES))) begin
            r_mem[i_widx] <= i_wbyte;
        end
    end

    assign o_rbyte = (i_ridx < 4'(KERNEL_3X3_BYTES)) ? r_mem[i_ridx] : 8'h00;

endmodule

// File: rtl/weight_stream_loader.sv
// Weight byte-stream loader: stages a kernel, replays it as a gap-free
// burst, then strobes wr_en with wr_addr/ch_cnt. Inputs: sclk, s_rst_n,
// start, conv_type_in, kernel_num, s_data/s_valid. Outputs: s_ready,
// weight_data_in/_vld, wr_en, wr_addr, ch_cnt, conv_type, busy, done.
module weight_stream_loader #(
    parameter  int ADDR_W = 8,
    parameter  int CH_NUM = 8,
    localparam int CH_W   = $clog2(CH_NUM)
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              start,
    input  logic              conv_type_in,
    input  logic [ADDR_W:0]   kernel_num,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        weight_data_in,
    output logic              weight_data_in_vld,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CH_W-1:0]   ch_cnt,
    output logic              conv_type,
    output logic              busy,
    output logic              done
);

    import cnn_pkg::*;

    ld_state_e         r_state;
    ld_state_e         w_next;
    logic              r_conv;
    logic [ADDR_W:0]   r_knum;
    logic [ADDR_W:0]   w_knum_m1;
    logic [3:0]        r_byte_cnt;
    logic [3:0]        r_emit_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [CH_W-1:0]   r_ch;
    logic [7:0]        r_data;
    logic              r_vld;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        w_k;
    logic              w_acc;
    logic              w_last_byte;
    logic              w_last_emit;
    logic              w_last_kernel;
    logic              w_ch_wrap;
    logic [3:0]        w_ridx;
    logic [7:0]        w_rbyte;

    assign w_k           = kernel_bytes(r_conv);
    assign w_acc         = (r_state == FILL) && s_valid;
    assign w_last_byte   = w_acc && (r_byte_cnt == w_k - 4'd1);
    assign w_last_emit   = (r_state == EMIT) && (r_emit_cnt == w_k - 4'd1);
    assign w_knum_m1     = r_knum - {{ADDR_W{1'b0}}, 1'b1};
    assign w_ch_wrap     = (r_ch == CH_W'(CH_NUM - 1));
    assign w_last_kernel = ({1'b0, r_addr} == w_knum_m1) && w_ch_wrap;
    // Look one byte ahead so the replay register is loaded in time.
    assign w_ridx        = (r_state == EMIT) ? r_emit_cnt + 4'd1 : 4'd0;

    weight_kernel_stage u_stage (
        .i_clk   (sclk),
        .i_rst_n (s_rst_n),
        .i_we    (w_acc),
        .i_widx  (r_byte_cnt),
        .i_wbyte (s_data),
        .i_ridx  (w_ridx),
        .o_rbyte (w_rbyte)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = (kernel_num == '0) ? DONE : FILL;
            end
            FILL: begin
                if (w_last_byte) w_next = EMIT;
            end
            EMIT: begin
                if (w_last_emit) w_next = WRITE;
            end
            WRITE: begin
                w_next = w_last_kernel ? DONE : FILL;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_conv     <= 1'b0;
            r_knum     <= '0;
            r_byte_cnt <= '0;
            r_emit_cnt <= '0;
            r_addr     <= '0;
            r_ch       <= '0;
            r_data     <= '0;
            r_vld      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_vld   <= (w_next == EMIT);
            r_wr_en <= (w_next == WRITE);
            r_done  <= (w_next == DONE);
            r_busy  <= (w_next != IDLE);
            if ((r_state == IDLE) && start) begin
                r_conv     <= conv_type_in;
                r_knum     <= kernel_num;
                r_byte_cnt <= '0;
                r_emit_cnt <= '0;
                r_addr     <= '0;
                r_ch       <= '0;
            end
            if (w_acc) begin
                r_byte_cnt <= w_last_byte ? 4'd0 : r_byte_cnt + 4'd1;
            end
            // A 1-byte kernel is still being written; bypass the stage.
            if (w_last_byte) begin
                r_data     <= (w_k == 4'd1) ? s_data : w_rbyte;
                r_emit_cnt <= '0;
            end else if (r_state == EMIT) begin
                r_emit_cnt <= r_emit_cnt + 4'd1;
                if (!w_last_emit) r_data <= w_rbyte;
            end
            if (r_state == WRITE) begin
                if (w_last_kernel) begin
                    r_addr <= '0;
                    r_ch   <= '0;
                end else begin
                    r_ch <= w_ch_wrap ? '0 : r_ch + 1'b1;
                    if (w_ch_wrap) r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign s_ready            = (r_state == FILL);
    assign weight_data_in     = r_data;
    assign weight_data_in_vld = r_vld;
    assign wr_en              = r_wr_en;
    assign wr_addr            = r_addr;
    assign ch_cnt             = r_ch;
    assign conv_type          = r_conv;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader.
// Monitors replay bursts into a model RAM and checks each scenario.
module tb_weight_stream_loader;

    logic       sclk = 1'b0;
    logic       s_rst_n;
    logic       start;
    logic       conv_type_in;
    logic [8:0] kernel_num;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] weight_data_in;
    logic       weight_data_in_vld;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [2:0] ch_cnt;
    logic       conv_type;
    logic       busy;
    logic       done;

    weight_stream_loader dut (
        .sclk               (sclk),
        .s_rst_n            (s_rst_n),
        .start              (start),
        .conv_type_in       (conv_type_in),
        .kernel_num         (kernel_num),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .weight_data_in     (weight_data_in),
        .weight_data_in_vld (weight_data_in_vld),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .ch_cnt             (ch_cnt),
        .conv_type          (conv_type),
        .busy               (busy),
        .done               (done)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;

    logic [71:0] ram [0:2047];
    int          cyc = 0;
    int          run = 0;
    int          exp_k = 9;
    int          wr_cnt, done_cnt, busy_cyc, bursts, bad_burst, bad_wr;
    int          min_gap, max_gap, last_wr_cyc;
    logic        ready_seen, prev_vld;
    logic [71:0] cur, last_word;
    logic [7:0]  first_a, last_a;
    logic [2:0]  first_c, last_c;

    always @(negedge sclk) begin
        cyc++;
        if (!s_rst_n) begin
            run = 0;
            cur = '0;
            prev_vld = 1'b0;
        end else begin
            if (weight_data_in_vld) begin
                cur |= 72'(weight_data_in) << (8 * run);
                run++;
            end else if (run != 0) begin
                bursts++;
                if (run != exp_k) bad_burst++;
                last_word = cur;
                cur = '0;
                run = 0;
            end
            if (wr_en) begin
                if (!prev_vld) bad_wr++;
                ram[{wr_addr, ch_cnt}] = last_word;
                if (wr_cnt == 0) begin
                    first_a = wr_addr;
                    first_c = ch_cnt;
                end else begin
                    if (cyc - last_wr_cyc < min_gap) min_gap = cyc - last_wr_cyc;
                    if (cyc - last_wr_cyc > max_gap) max_gap = cyc - last_wr_cyc;
                end
                last_wr_cyc = cyc;
                last_a = wr_addr;
                last_c = ch_cnt;
                wr_cnt++;
            end
            prev_vld = weight_data_in_vld;
            if (done)    done_cnt++;
            if (s_ready) ready_seen = 1'b1;
            if (busy)    busy_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input int k);
        for (int i = 0; i < 2048; i++) ram[i] = 'x;
        exp_k = k;
        wr_cnt = 0;
        done_cnt = 0;
        busy_cyc = 0;
        bursts = 0;
        bad_burst = 0;
        bad_wr = 0;
        min_gap = 1000000;
        max_gap = 0;
        ready_seen = 1'b0;
        last_word = '0;
    endtask

    task automatic do_start(input logic ct, input logic [8:0] kn);
        @(negedge sclk);
        start = 1'b1;
        conv_type_in = ct;
        kernel_num = kn;
        @(negedge sclk);
        start = 1'b0;
    endtask

    task automatic send(input int n, input int base, input bit gap);
        int i = 0;
        int t = 0;
        logic acc;
        while (i < n && t < n * 25 + 100) begin
            s_data = 8'(base + i);
            s_valid = gap ? ~s_valid : 1'b1;
            acc = s_valid && s_ready;
            @(negedge sclk);
            if (acc) i++;
            t++;
        end
        s_valid = 1'b0;
        chk("send_bound", 72'(i), 72'(n));
    endtask

    task automatic wait_idle(input int lim);
        int t = 0;
        while (busy && t < lim) begin
            @(negedge sclk);
            t++;
        end
        @(negedge sclk);
        chk("idle_bound", 72'(busy), 72'(0));
    endtask

    initial begin
        s_rst_n = 1'b0;
        start = 1'b0;
        conv_type_in = 1'b0;
        kernel_num = '0;
        s_data = '0;
        s_valid = 1'b0;
        clear_stats(9);
        repeat (3) @(negedge sclk);
        chk("rst_outs", {weight_data_in, weight_data_in_vld, wr_en, wr_addr,
                         ch_cnt, conv_type, busy, done, s_ready}, 72'(0));
        s_rst_n = 1'b1;
        @(negedge sclk);
        chk("idle_outs", {wr_en, busy, done, s_ready}, 72'(0));

        // 1: 3x3, one address, contiguous bytes
        clear_stats(9);
        do_start(1'b0, 9'd1);
        chk("s1_busy", 72'(busy), 72'(1));
        send(72, 1, 1'b0);
        wait_idle(100);
        chk("s1_wr", 72'(wr_cnt), 72'(8));
        chk("s1_bursts", 72'(bursts), 72'(8));
        chk("s1_badburst", 72'(bad_burst), 72'(0));
        chk("s1_wr_after_vld", 72'(bad_wr), 72'(0));
        chk("s1_done", 72'(done_cnt), 72'(1));
        chk("s1_ram0", ram[0], 72'h090807060504030201);
        chk("s1_ram7", ram[7], 72'h484746454443424140);
        chk("s1_last", {last_a, last_c}, {8'd0, 3'd7});

        // 2: 1x1, two addresses
        clear_stats(1);
        do_start(1'b1, 9'd2);
        chk("s2_conv", 72'(conv_type), 72'(1));
        send(16, 8'hA0, 1'b0);
        wait_idle(100);
        chk("s2_wr", 72'(wr_cnt), 72'(16));
        chk("s2_ram0", ram[0], 72'hA0);
        chk("s2_ram9", ram[9], 72'hA9);
        chk("s2_ram15", ram[15], 72'hAF);
        chk("s2_last", {last_a, last_c}, {8'd1, 3'd7});
        chk("s2_mingap", 72'(min_gap), 72'(3));
        chk("s2_maxgap", 72'(max_gap), 72'(3));
        chk("s2_badburst", 72'(bad_burst), 72'(0));

        // 3: 3x3 with s_valid toggling during FILL
        clear_stats(9);
        do_start(1'b0, 9'd1);
        send(72, 1, 1'b1);
        wait_idle(100);
        chk("s3_wr", 72'(wr_cnt), 72'(8));
        chk("s3_badburst", 72'(bad_burst), 72'(0));
        chk("s3_ram0", ram[0], 72'h090807060504030201);
        chk("s3_ram3", ram[3], 72'h24232221201F1E1D1C);
        chk("s3_ram7", ram[7], 72'h484746454443424140);

        // 4: kernel_num = 0
        clear_stats(9);
        do_start(1'b0, 9'd0);
        wait_idle(10);
        chk("s4_busycyc", 72'(busy_cyc), 72'(1));
        chk("s4_done", 72'(done_cnt), 72'(1));
        chk("s4_wr", 72'(wr_cnt), 72'(0));
        chk("s4_ready", 72'(ready_seen), 72'(0));

        // 5: reset during EMIT of addr0/ch3
        clear_stats(9);
        do_start(1'b0, 9'd1);
        send(36, 1, 1'b0);
        chk("s5_in_emit", {72'(weight_data_in_vld), 72'(ch_cnt)}, {72'(1), 72'(3)});
        @(negedge sclk);
        s_rst_n = 1'b0;
        #1;
        chk("s5_rst_outs", {weight_data_in, weight_data_in_vld, wr_en, wr_addr,
                            ch_cnt, conv_type, busy, done, s_ready}, 72'(0));
        @(negedge sclk);
        s_rst_n = 1'b1;
        repeat (3) @(negedge sclk);
        chk("s5_nodone", 72'(done_cnt), 72'(0));
        chk("s5_wr_before", 72'(wr_cnt), 72'(3));
        clear_stats(9);
        do_start(1'b0, 9'd1);
        send(72, 1, 1'b0);
        wait_idle(100);
        chk("s5_first", {first_a, first_c}, {8'd0, 3'd0});
        chk("s5_wr", 72'(wr_cnt), 72'(8));
        chk("s5_ram0", ram[0], 72'h090807060504030201);
        chk("s5_done", 72'(done_cnt), 72'(1));

        // 6: full 256-address 1x1 load with a stray start
        clear_stats(1);
        do_start(1'b1, 9'd256);
        send(100, 0, 1'b0);
        do_start(1'b0, 9'd1);
        chk("s6_conv_hold", {72'(conv_type), 72'(busy)}, {72'(1), 72'(1)});
        send(1948, 100, 1'b0);
        wait_idle(100);
        chk("s6_wr", 72'(wr_cnt), 72'(2048));
        chk("s6_last", {last_a, last_c}, {8'd255, 3'd7});
        chk("s6_done", 72'(done_cnt), 72'(1));
        chk("s6_ram0", ram[0], 72'h00);
        chk("s6_ram1000", ram[1000], 72'hE8);
        chk("s6_ram2047", ram[2047], 72'hFF);
        chk("s6_badburst", 72'(bad_burst), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
